// File: rtl/flush_redirect_ctrl_if.sv
// Signal bundle between the WB/CSR side, the fetch stage and the flush/redirect sequencer.
interface flush_redirect_ctrl_if #(
  parameter int CNT_W = 2
);
  logic             ws_ex;
  logic             ws_ertn;
  logic [31:0]      ex_entry;
  logic [31:0]      ertn_era;
  logic             inst_req_fire;
  logic             inst_resp_fire;
  logic             fs_redirect_ready;
  logic             flush_pipe;
  logic             discard_resp;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] outst_cnt;

  modport master (
    output ws_ex, ws_ertn, ex_entry, ertn_era,
    output inst_req_fire, inst_resp_fire, fs_redirect_ready,
    input  flush_pipe, discard_resp, redirect_valid, redirect_pc, outst_cnt
  );

  modport slave (
    input  ws_ex, ws_ertn, ex_entry, ertn_era,
    input  inst_req_fire, inst_resp_fire, fs_redirect_ready,
    output flush_pipe, discard_resp, redirect_valid, redirect_pc, outst_cnt
  );
endinterface

// File: rtl/flush_redirect_ctrl.sv
// Flushes the pipeline on a WB exception/ERTN, drops responses of the stale fetch
// stream, then presents the redirect PC until the fetch stage accepts it.
module flush_redirect_ctrl #(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  flush_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    REDIRECT
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  state_t           state;
  logic [CNT_W-1:0] outst_cnt_q;
  logic [CNT_W-1:0] discard_cnt;
  logic [31:0]      redirect_pc_q;

  logic             req_eff;
  logic             resp_eff;
  logic [CNT_W-1:0] outst_next;
  logic [CNT_W-1:0] discard_next;
  logic             event_fire;
  logic [31:0]      target_pc;

  // Counter guards keep the in-flight count inside 0..MAX_OUTST even on illegal traffic.
  always_comb begin
    req_eff      = bus.inst_req_fire && (outst_cnt_q != MAX_CNT);
    resp_eff     = bus.inst_resp_fire && (outst_cnt_q != '0);
    outst_next   = outst_cnt_q + CNT_W'(req_eff) - CNT_W'(resp_eff);
    discard_next = discard_cnt + CNT_W'(bus.inst_req_fire)
                   - CNT_W'(bus.inst_resp_fire && (discard_cnt != '0));
    event_fire   = (state == IDLE) && (bus.ws_ex || bus.ws_ertn);
    target_pc    = bus.ws_ex ? bus.ex_entry : bus.ertn_era;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      outst_cnt_q   <= '0;
      discard_cnt   <= '0;
      redirect_pc_q <= '0;
    end else begin
      outst_cnt_q <= outst_cnt_q + CNT_W'(req_eff) - CNT_W'(resp_eff);
      case (state)
        IDLE: begin
          if (event_fire) begin
            redirect_pc_q <= target_pc;
            if (outst_next != '0) begin
              state       <= DRAIN;
              discard_cnt <= outst_next;
            end else begin
              state <= REDIRECT;
            end
          end
        end
        DRAIN: begin
          discard_cnt <= discard_next;
          if (discard_next == '0) begin
            state <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (bus.fs_redirect_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The event cycle itself must already kill younger stages and drop its response.
  assign bus.flush_pipe     = event_fire || (state != IDLE);
  assign bus.discard_resp   = bus.inst_resp_fire && (event_fire || (state == DRAIN));
  assign bus.redirect_valid = (state == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.outst_cnt      = outst_cnt_q;

  req_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(bus.inst_req_fire && (outst_cnt_q == MAX_CNT)));

  resp_underflow_a: assert property (@(posedge clk) disable iff (reset)
    !(bus.inst_resp_fire && (outst_cnt_q == '0)));

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Bench for flush_redirect_ctrl: directed scenarios plus random traffic, all checked
// against a model that tracks in-flight fetch requests as a queue tagged old/new stream.
module tb_flush_redirect_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  flush_redirect_ctrl_if #(.CNT_W(2)) bus ();

  flush_redirect_ctrl #(.MAX_OUTST(2), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: each in-flight request is one queue entry, 1 = belongs to the flushed stream.
  bit          q[$];
  bit          flushing = 1'b0;
  logic [31:0] m_pc = 32'h0;
  bit          ev;
  bit          e_rv;
  logic [36:0] exp_vec;

  function automatic int stale_count();
    int n = 0;
    foreach (q[i]) n += int'(q[i]);
    return n;
  endfunction

  function automatic logic [36:0] obs_vec();
    return {bus.flush_pipe, bus.discard_resp, bus.redirect_valid, bus.redirect_pc, bus.outst_cnt};
  endfunction

  task automatic model_eval();
    bit e_disc;
    ev     = !flushing && (bus.ws_ex || bus.ws_ertn);
    e_disc = bus.inst_resp_fire && (ev || (flushing && q.size() > 0 && q[0]));
    e_rv   = flushing && (stale_count() == 0);
    exp_vec = {ev || flushing, e_disc, e_rv, m_pc, 2'(q.size())};
  endtask

  task automatic commit();
    bit was_flush = flushing;
    if (reset) begin
      q.delete();
      flushing = 1'b0;
      m_pc     = 32'h0;
      return;
    end
    if (e_rv && bus.fs_redirect_ready) flushing = 1'b0;
    if (bus.inst_resp_fire && q.size() > 0) void'(q.pop_front());
    if (bus.inst_req_fire) q.push_back(was_flush || ev);
    if (ev) begin
      foreach (q[i]) q[i] = 1'b1;
      flushing = 1'b1;
      m_pc     = bus.ws_ex ? bus.ex_entry : bus.ertn_era;
    end
  endtask

  task automatic drive(input logic rst, input logic ex, input logic ertn,
                       input logic [31:0] entry, input logic [31:0] era,
                       input logic req, input logic resp, input logic ready);
    @(negedge clk);
    reset                 = rst;
    bus.ws_ex             = ex;
    bus.ws_ertn           = ertn;
    bus.ex_entry          = entry;
    bus.ertn_era          = era;
    bus.inst_req_fire     = req;
    bus.inst_resp_fire    = resp;
    bus.fs_redirect_ready = ready;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    drive(1'b1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    commit();
    drive(1'b1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    commit();
    drive(1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    n_cmp++;
    if (obs_vec() !== 37'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h want %h", obs_vec(), 37'h0);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec) begin
      n_fail++;
      $display("[TB] FAIL reset_model: got %h want %h", obs_vec(), exp_vec);
    end
    commit();
  endtask

  task automatic test_ex_min_latency();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, k == 0, 0, 32'h1C008000, 32'h0, 0, 0, 1);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL ex_latency k%0d: got %h want %h", k, obs_vec(), exp_vec);
      end
      if (k == 0) begin
        n_cmp++;
        if (bus.flush_pipe !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL ex_latency_flush: got %b want 1", bus.flush_pipe);
        end
      end
      if (k == 1) begin
        n_cmp++;
        if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h1C008000}) begin
          n_fail++;
          $display("[TB] FAIL ex_latency_redirect: got %b/%h want 1/1c008000",
                   bus.redirect_valid, bus.redirect_pc);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if ({bus.flush_pipe, bus.redirect_valid} !== 2'b00) begin
          n_fail++;
          $display("[TB] FAIL ex_latency_idle: got %b%b want 00", bus.flush_pipe, bus.redirect_valid);
        end
      end
      commit();
    end
  endtask

  task automatic test_ertn_drain();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 0, k == 2, 32'h0, 32'h1C000124, k < 2, (k == 5) || (k == 7), k == 8);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL ertn_drain k%0d: got %h want %h", k, obs_vec(), exp_vec);
      end
      if (k >= 2 && k <= 8) begin
        n_cmp++;
        if (bus.discard_resp !== ((k == 5) || (k == 7))) begin
          n_fail++;
          $display("[TB] FAIL ertn_discard k%0d: got %b want %b", k, bus.discard_resp, (k == 5) || (k == 7));
        end
        n_cmp++;
        if (bus.redirect_valid !== (k == 8)) begin
          n_fail++;
          $display("[TB] FAIL ertn_rvalid k%0d: got %b want %b", k, bus.redirect_valid, k == 8);
        end
      end
      commit();
    end
  endtask

  task automatic test_both_events();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k < 2, k < 2, 32'h1C00A000, 32'h1C000300, 0, 0, 1);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL both_events k%0d: got %h want %h", k, obs_vec(), exp_vec);
      end
      if (k == 1) begin
        n_cmp++;
        if (bus.redirect_pc !== 32'h1C00A000) begin
          n_fail++;
          $display("[TB] FAIL both_events_pc: got %h want 1c00a000", bus.redirect_pc);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (bus.flush_pipe !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL both_events_single: got %b want 0", bus.flush_pipe);
        end
      end
      commit();
    end
  endtask

  task automatic test_req_in_event();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, k == 1, 0, 32'h1C00B000, 32'h0, k < 2, (k == 2) || (k == 3), k == 4);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL req_in_event k%0d: got %h want %h", k, obs_vec(), exp_vec);
      end
      if (k == 2 || k == 3) begin
        n_cmp++;
        if ({bus.discard_resp, bus.redirect_valid} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL req_in_event_drop k%0d: got %b%b want 10", k,
                   bus.discard_resp, bus.redirect_valid);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (bus.redirect_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL req_in_event_redirect: got %b want 1", bus.redirect_valid);
        end
      end
      commit();
    end
  endtask

  task automatic test_redirect_stall();
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, (k == 0) || (k == 2), 0, (k == 0) ? 32'h1C004000 : 32'h1C007777,
            32'h0, 0, 0, k == 5);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL redirect_stall k%0d: got %h want %h", k, obs_vec(), exp_vec);
      end
      if (k >= 1 && k <= 5) begin
        n_cmp++;
        if ({bus.flush_pipe, bus.redirect_valid, bus.redirect_pc} !== {2'b11, 32'h1C004000}) begin
          n_fail++;
          $display("[TB] FAIL redirect_stall_hold k%0d: got %b%b/%h want 11/1c004000", k,
                   bus.flush_pipe, bus.redirect_valid, bus.redirect_pc);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (bus.flush_pipe !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL redirect_stall_exit: got %b want 0", bus.flush_pipe);
        end
      end
      commit();
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 6; k++) begin
      drive(k == 4, 0, k == 2, 32'h0, 32'h1C000500, k < 2, k == 3, 0);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_drain k%0d: got %h want %h", k, obs_vec(), exp_vec);
      end
      if (k == 5) begin
        n_cmp++;
        if (obs_vec() !== 37'h0) begin
          n_fail++;
          $display("[TB] FAIL reset_mid_drain_clear: got %h want 0", obs_vec());
        end
      end
      commit();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      logic rst, ex, ertn, req, resp, ready;
      rst   = ($urandom_range(0, 249) == 0);
      ex    = ($urandom_range(0, 11) == 0);
      ertn  = ($urandom_range(0, 11) == 0);
      req   = (q.size() < 2) && (!flushing || stale_count() > 0) && ($urandom_range(0, 2) == 0);
      resp  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      ready = ($urandom_range(0, 1) == 0);
      drive(rst, ex, ertn, $urandom, $urandom, req, resp, ready);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL random k%0d: got %h want %h", k, obs_vec(), exp_vec);
      end
      commit();
    end
  endtask

  initial begin
    bus.ws_ex             = 1'b0;
    bus.ws_ertn           = 1'b0;
    bus.ex_entry          = 32'h0;
    bus.ertn_era          = 32'h0;
    bus.inst_req_fire     = 1'b0;
    bus.inst_resp_fire    = 1'b0;
    bus.fs_redirect_ready = 1'b0;
    test_reset();
    test_ex_min_latency();
    test_ertn_drain();
    test_both_events();
    test_req_in_event();
    test_redirect_stall();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
